// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle control unit driving the ULA from a 16x8 register bank
// Optional feature: define BRANCH_ZERO_EN to enable the zero flag and the BZ instruction (opcode 1110).
module unidade_controle #(
  parameter int LARGURA_DADO = 8,
  parameter int LARGURA_PC   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  output logic [LARGURA_PC-1:0]   instr_endereco,
  input  logic [15:0]             instr_dado,
  input  logic                    instr_valido,
  output logic [LARGURA_DADO-1:0] regA,
  output logic [LARGURA_DADO-1:0] regB,
  output logic [3:0]              opcode,
  output logic [3:0]              endereco,
  output logic                    enable,
  input  logic [LARGURA_DADO-1:0] saidaULA,
  output logic [3:0]              dado_endereco,
  output logic [LARGURA_DADO-1:0] dado_saida,
  output logic                    dado_escrita,
  output logic                    ocupado,
  output logic                    parado
);

  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_LOADI = 4'b1101;
  localparam logic [3:0] OP_BZ    = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    OCIOSO, BUSCA, ESPERA, DECODIFICA, EXECUTA, ESCREVE, PARADO
  } estado_t;

  estado_t                 estado, proximo;
  logic [LARGURA_PC-1:0]   pc;
  logic [15:0]             ir;
  logic [LARGURA_DADO-1:0] banco [16];
  logic [LARGURA_DADO-1:0] op_a, op_b;
  logic [3:0]              op_code, op_dst;
  logic                    eh_ula;
`ifdef BRANCH_ZERO_EN
  logic [7:0]              flag_zero;
`endif

  assign eh_ula = (op_code < OP_STORE);

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO, PARADO: if (iniciar) proximo = BUSCA;
      BUSCA:          proximo = ESPERA;
      ESPERA:         if (instr_valido) proximo = DECODIFICA;
      DECODIFICA:     proximo = EXECUTA;
      EXECUTA:        proximo = (op_code == OP_HALT) ? PARADO : ESCREVE;
      ESCREVE:        proximo = BUSCA;
      default:        proximo = OCIOSO;
    endcase
  end

  // Operands are registered in DECODIFICA, so a write to a source register uses the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      pc      <= '0;
      ir      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      op_dst  <= '0;
      for (int i = 0; i < 16; i++) banco[i] <= '0;
`ifdef BRANCH_ZERO_EN
      flag_zero <= '0;
`endif
    end else begin
      estado <= proximo;
      case (estado)
        OCIOSO, PARADO: if (iniciar) pc <= '0;
        ESPERA:         if (instr_valido) ir <= instr_dado;
        DECODIFICA: begin
          op_code <= ir[15:12];
          op_dst  <= ir[11:8];
          op_a    <= banco[ir[7:4]];
          op_b    <= banco[ir[3:0]];
        end
        ESCREVE: begin
          pc <= pc + LARGURA_PC'(1);
          if (eh_ula) begin
            banco[op_dst] <= saidaULA;
`ifdef BRANCH_ZERO_EN
            flag_zero <= {7'b0, (saidaULA == '0)};
`endif
          end else if (op_code == OP_LOADI) begin
            banco[op_dst] <= LARGURA_DADO'(ir[7:0]);
          end
`ifdef BRANCH_ZERO_EN
          else if (op_code == OP_BZ && flag_zero != '0) begin
            pc <= LARGURA_PC'(ir[7:0]);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign instr_endereco = pc;
  assign regA           = op_a;
  assign regB           = op_b;
  assign opcode         = op_code;
  assign endereco       = op_dst;
  assign enable         = (estado == EXECUTA) && eh_ula;
  assign dado_escrita   = (estado == EXECUTA) && (op_code == OP_STORE);
  assign dado_endereco  = op_dst;
  assign dado_saida     = op_a;
  assign ocupado        = (estado != OCIOSO) && (estado != PARADO);
  assign parado         = (estado == PARADO);

endmodule
